memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum cycles a granted transaction may wait for RAM ACCESS before it is aborted.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  instruction address.
REQ-006 iload  out  32  fetched instruction word.
REQ-007 iwait  out  1  high while the fetch is not complete.
REQ-008 dREN, dWEN  in  1 each  data read and write requests.
REQ-009 daddr, dstore  in  32 each  data address and store data.
REQ-010 dload  out  32  loaded data word.
REQ-011 dwait  out  1  high while the data access is not complete.
REQ-012 ramstate  in  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).
REQ-013 ramload  in  32  RAM read data.
REQ-014 ramaddr, ramstore  out  32 each  registered RAM address and store data.
REQ-015 ramREN, ramWEN  out  1 each  registered RAM strobes.
REQ-016 memerr  out  1  sticky error flag, set on RAM ERROR or timeout.

Function
REQ-017 FSM states: IDLE, DGRANT, IGRANT. State is held in a single registered state variable.
REQ-018 In IDLE, with a data request only (dREN|dWEN), latch daddr, dstore and the operation, then go to DGRANT.
REQ-019 In IDLE, with iREN only, latch iaddr, then go to IGRANT.
REQ-020 In IDLE, with both requests pending, grant data unless the last completed grant was data. In that case grant instruction. The last-grant flag resets to "instruction".
REQ-021 When dREN and dWEN are both high, the access is treated as a write only.
REQ-022 In DGRANT and IGRANT, RAM outputs are driven from the latched registers. Exactly one of ramREN/ramWEN is high.
REQ-023 On ramstate==ACCESS, the granted requester's wait goes low for exactly that cycle. For reads, iload/dload = ramload in that same cycle. The FSM returns to IDLE on the next edge.
REQ-024 Minimum latency: request sampled at edge N, wait low during cycle N+1 (provided RAM returns ACCESS immediately).
REQ-025 No new grant is issued in the completion cycle; a back-to-back request is granted at the earliest one cycle later.
REQ-026 The non-granted requester's wait stays high. iwait/dwait are low only when the corresponding request is deasserted or completing.
REQ-027 A timeout counter clears on every grant and increments each granted cycle without ACCESS.
REQ-028 When the counter reaches TIMEOUT_CYC-1, or ramstate==ERROR, the FSM:
  - completes the transaction as in REQ-023, with load data forced to 0;
  - sets memerr.
REQ-029 If a request drops mid-grant, the latched transaction still runs to completion; stores are never abandoned.
REQ-030 The counter width is $clog2(TIMEOUT_CYC)+1 and saturates; it never wraps.
REQ-031 In IDLE: ramREN=ramWEN=0, ramaddr and ramstore hold their last values, iload=dload=0.

Reset
REQ-032 On nRST low, immediately:
  - state=IDLE, memerr=0, timeout counter=0, last-grant=instruction;
  - ramREN=ramWEN=0, ramaddr=ramstore=0;
  - iwait=iREN, dwait=(dREN|dWEN).
REQ-033 A reset during a grant aborts the transaction. No completion pulse is produced.

Structure
REQ-034 ramstate_t and word_t come from cpu_types_pkg. The arbiter state enum and the default TIMEOUT_CYC are added to that package.
REQ-035 No sub-module is required. The timeout counter may be factored as sub-module arb_timer.

Verification
REQ-036 Single fetch: iREN=1, iaddr=0x40, RAM returns ACCESS 2 cycles after grant with ramload=0x3C010001 -> iwait low exactly 1 cycle, iload=0x3C010001, ramREN high 3 cycles.
REQ-037 Contention, held for 4 transactions: iREN=1 and dREN=1 simultaneously, immediate ACCESS -> grant order D, I, D, I; neither requester waits more than 2 grants.
REQ-038 Store: dWEN=1, daddr=0x80, dstore=0xDEADBEEF, BUSY 3 cycles then ACCESS -> ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF stable for all 4 cycles; dwait low in the 4th cycle.
REQ-039 Timeout: TIMEOUT_CYC=8, ramstate=BUSY forever -> dwait low in grant cycle 8, dload=0, memerr=1 and sticky afterward.
REQ-040 Reset mid-grant: nRST low in cycle 2 of an IGRANT -> ramREN=0 and state IDLE asynchronously; no iwait low pulse; after release, the next request behaves per REQ-036.
REQ-041 dREN=dWEN=1, daddr=0x10 -> ramWEN=1, ramREN=0 throughout the grant.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake status, machine word, and memory arbiter state/defaults.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_CYC = 64;

endpackage

// File: rtl/arb_timer.sv
// Saturating wait counter for a granted RAM transaction; flags the last permitted cycle.
module arb_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: alternates data/instruction grants under contention,
// with timeout and RAM-error recovery reported through a sticky memerr flag.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  input  ramstate_t   ramstate,
  input  logic [31:0] ramload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic        memerr
);

  arb_state_t  state_q, state_d;
  logic [31:0] addr_q, store_q;
  logic        ram_ren_q, ram_wen_q;
  logic        last_d_q;
  logic        memerr_q;

  logic d_req, granted, access, fault, done, expired;
  logic grant_d, grant_i;

  assign d_req   = dREN | dWEN;
  assign granted = (state_q != IDLE);
  assign access  = (ramstate == ACCESS);
  // A genuine ACCESS wins over a coincident timeout so real data is never discarded.
  assign fault   = !access && ((ramstate == ERROR) || expired);
  assign done    = granted && (access || fault);

  arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (grant_d | grant_i),
    .inc     (granted && !access),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    iwait   = iREN;
    dwait   = d_req;
    iload   = '0;
    dload   = '0;
    case (state_q)
      IDLE: begin
        if (d_req && (!iREN || !last_d_q)) begin
          grant_d = 1'b1;
          state_d = DGRANT;
        end else if (iREN) begin
          grant_i = 1'b1;
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (done) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (access && !ram_wen_q) dload = ramload;
        end
      end
      IGRANT: begin
        if (done) begin
          iwait   = 1'b0;
          state_d = IDLE;
          if (access) iload = ramload;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched transaction: address/store hold their last values while idle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q    <= '0;
      store_q   <= '0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
    end else if (grant_d) begin
      addr_q    <= daddr;
      store_q   <= dstore;
      ram_ren_q <= !dWEN;
      ram_wen_q <= dWEN;
    end else if (grant_i) begin
      addr_q    <= iaddr;
      ram_ren_q <= 1'b1;
      ram_wen_q <= 1'b0;
    end else if (done) begin
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d_q <= 1'b0;
      memerr_q <= 1'b0;
    end else if (done) begin
      last_d_q <= (state_q == DGRANT);
      if (fault) memerr_q <= 1'b1;
    end
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter: one vector per clock cycle plus hand-written reset sequences.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TOUT = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, memerr;

  int applied     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT_CYC(TOUT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramstate (ramstate),
    .ramload  (ramload),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .memerr   (memerr)
  );

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    ramstate_t   rs;
    logic [31:0] rload;
    logic        e_iwait;
    logic        e_dwait;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_raddr;
    logic [31:0] e_rstore;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic iren, input logic [31:0] ia, input logic dren, input logic dwen,
    input logic [31:0] da, input logic [31:0] ds, input ramstate_t rs, input logic [31:0] rl,
    input logic eiw, input logic edw, input logic [31:0] eil, input logic [31:0] edl,
    input logic eren, input logic ewen, input logic [31:0] era, input logic [31:0] ers,
    input logic eerr);
    vec_t v;
    v.iren = iren; v.iaddr = ia; v.dren = dren; v.dwen = dwen;
    v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
    v.e_iwait = eiw; v.e_dwait = edw; v.e_iload = eil; v.e_dload = edl;
    v.e_ren = eren; v.e_wen = ewen; v.e_raddr = era; v.e_rstore = ers; v.e_err = eerr;
    return v;
  endfunction

  task automatic expect1(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < vq.size(); k++) begin
      @(posedge CLK);
      #1;
      iREN = vq[k].iren;   iaddr  = vq[k].iaddr;
      dREN = vq[k].dren;   dWEN   = vq[k].dwen;
      daddr = vq[k].daddr; dstore = vq[k].dstore;
      ramstate = vq[k].rs; ramload = vq[k].rload;
      @(negedge CLK);
      applied++;
      if (iwait !== vq[k].e_iwait || dwait !== vq[k].e_dwait ||
          iload !== vq[k].e_iload || dload !== vq[k].e_dload ||
          ramREN !== vq[k].e_ren  || ramWEN !== vq[k].e_wen ||
          ramaddr !== vq[k].e_raddr || ramstore !== vq[k].e_rstore ||
          memerr !== vq[k].e_err) begin
        miscompares++;
        $display("FAIL %s[%0d]: got iwait=%b dwait=%b iload=%h dload=%h ren=%b wen=%b raddr=%h rstore=%h memerr=%b, expected %b %b %h %h %b %b %h %h %b",
                 tag, k, iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr,
                 vq[k].e_iwait, vq[k].e_dwait, vq[k].e_iload, vq[k].e_dload, vq[k].e_ren,
                 vq[k].e_wen, vq[k].e_raddr, vq[k].e_rstore, vq[k].e_err);
      end
    end
    vq.delete();
  endtask

  task automatic add_fetch();
    vq.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0,
                    1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0,
                      1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h3C010001,
                    1'b0, 1'b0, 32'h3C010001, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0));
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 1'b1; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramstate = FREE; ramload = 32'h0;

    // Reset state with a pending fetch
    #12;
    expect1("rst_iwait",  32'(iwait),  32'd1);
    expect1("rst_dwait",  32'(dwait),  32'd0);
    expect1("rst_ramREN", 32'(ramREN), 32'd0);
    expect1("rst_ramaddr", ramaddr,    32'h0);
    expect1("rst_memerr", 32'(memerr), 32'd0);
    iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    add_fetch();
    // Contention: D, I, D, I with immediate ACCESS
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h77,
                    1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'hD0,
                    1'b1, 1'b0, 32'h0, 32'hD0, 1'b1, 1'b0, 32'h84, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h77,
                    1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h84, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h1A,
                    1'b0, 1'b1, 32'h1A, 32'h0, 1'b1, 1'b0, 32'h44, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h77,
                    1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h44, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'hD1,
                    1'b1, 1'b0, 32'h0, 32'hD1, 1'b1, 1'b0, 32'h84, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h77,
                    1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h84, 32'h11, 1'b0));
    vq.push_back(mk(1'b1, 32'h44, 1'b1, 1'b0, 32'h84, 32'h11, ACCESS, 32'h1B,
                    1'b0, 1'b1, 32'h1B, 32'h0, 1'b1, 1'b0, 32'h44, 32'h11, 1'b0));
    // Store with 3 BUSY cycles
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, FREE, 32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h44, 32'h11, 1'b0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, BUSY, 32'h0,
                      1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, ACCESS, 32'h12345678,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0));
    // dREN and dWEN together behave as a write
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55, FREE, 32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55, BUSY, 32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h55, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h55, ACCESS, 32'hAAAA,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h55, 1'b0));
    // Read whose request drops mid-grant still completes from latched address
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h99, FREE, 32'h0,
                    1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h10, 32'h55, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'hFF, 32'hEE, BUSY, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h99, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'hFF, 32'hEE, ACCESS, 32'hCAFEF00D,
                    1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h20, 32'h99, 1'b0));
    // Timeout after TOUT granted cycles of BUSY
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, BUSY, 32'hFFFFFFFF,
                    1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h20, 32'h99, 1'b0));
    for (int k = 0; k < TOUT - 1; k++)
      vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, BUSY, 32'hFFFFFFFF,
                      1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, BUSY, 32'hFFFFFFFF,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'hFFFFFFFF,
                      1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h30, 32'h0, 1'b1));
    run_table("main");

    // Reset asserted in the second cycle of an instruction grant
    @(posedge CLK);
    #1;
    iREN = 1'b1; iaddr = 32'h60; dREN = 1'b0; dWEN = 1'b0; ramstate = BUSY;
    @(posedge CLK);
    #1;
    expect1("rg_ramREN_g1", 32'(ramREN), 32'd1);
    expect1("rg_ramaddr_g1", ramaddr, 32'h60);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    expect1("rg_ramREN_async",  32'(ramREN), 32'd0);
    expect1("rg_state_async",   32'(dut.state_q), 32'(IDLE));
    expect1("rg_iwait_async",   32'(iwait), 32'd1);
    expect1("rg_ramaddr_async", ramaddr, 32'h0);
    expect1("rg_memerr_async",  32'(memerr), 32'd0);
    ramstate = ACCESS;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      expect1("rg_iwait_held", 32'(iwait), 32'd1);
    end
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;

    // Fetch after reset release, then a RAM ERROR completion
    add_fetch();
    vq.push_back(mk(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0,
                    1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h5555,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h50, 32'h0, 1'b1));
    run_table("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
